// File: rtl/alu_seq.sv
// alu_seq: registered ALU (AND/OR/NOR/ADD/SUB/SLT single-cycle, MULLO/MULHI shift-add) with start/ready/done handshake
// Ports: clk_i clock, rst_i async active-high reset, start_i/ctrl_i/src1_i/src2_i request sampled on accept,
//        ready_o idle, done_o one-cycle result pulse, result_o/zero_o/cout_o/overflow_o result and flags
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, MUL} state_t;
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_mplier, w_b, w_res;
    logic [WIDTH:0]     w_sum;
    logic               r_hi, w_sub, w_ovf, w_cout, w_v, w_is_mul;
    always_comb begin
        w_sub     = ctrl_i == 4'b0110 || ctrl_i == 4'b0111;
        w_b       = w_sub ? ~src2_i : src2_i;
        w_sum     = {1'b0, src1_i} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_sub};
        w_ovf     = (src1_i[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != src1_i[WIDTH-1]);
        // SLT uses sign xor overflow so it stays correct when A-B wraps
        w_res     = ctrl_i == 4'b0000 ? src1_i & src2_i :
                    ctrl_i == 4'b0001 ? src1_i | src2_i :
                    ctrl_i == 4'b1100 ? ~(src1_i | src2_i) :
                    (ctrl_i == 4'b0010 || ctrl_i == 4'b0110) ? w_sum[WIDTH-1:0] :
                    ctrl_i == 4'b0111 ? {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf} : '0;
        w_cout    = (ctrl_i == 4'b0010 || w_sub) && w_sum[WIDTH];
        w_v       = (ctrl_i == 4'b0010 || ctrl_i == 4'b0110) && w_ovf;
        w_is_mul  = ctrl_i == 4'b1000 || ctrl_i == 4'b1001;
        // multiplicand and multiplier shift each step, so bit 0 is multiplier bit[counter]
        w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    end
    assign zero_o = result_o == '0;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_hi       <= 1'b0;
            ready_o    <= 1'b1;
            done_o     <= 1'b0;
            result_o   <= '0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (r_state == IDLE && start_i && ready_o) begin
                if (w_is_mul) begin
                    r_mcand  <= {{WIDTH{1'b0}}, src1_i};
                    r_mplier <= src2_i;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_hi     <= ctrl_i[0];
                    r_state  <= MUL;
                    ready_o  <= 1'b0;
                end else begin
                    result_o   <= w_res;
                    cout_o     <= w_cout;
                    overflow_o <= w_v;
                    done_o     <= 1'b1;
                end
            end else if (r_state == MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                // last iteration loads the result directly from the final sum
                if (r_cnt == CW'(WIDTH - 1)) begin
                    result_o   <= r_hi ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];
                    overflow_o <= !r_hi && (|w_acc_nxt[2*WIDTH-1:WIDTH]);
                    cout_o     <= 1'b0;
                    done_o     <= 1'b1;
                    ready_o    <= 1'b1;
                    r_state    <= IDLE;
                end
            end
        end
    end
endmodule
